// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: round-robin between ALU and load
// writeback, plus a one-register-per-cycle "clear all" sweep. Write port outputs are registered.
module regfile_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_X0  = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wenable,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] Dc
);
    // Handshake: a requester holds valid/rd/data stable; the write is taken on the
    // rising edge where valid && ready. ready is combinational and never depends on
    // anything the requester does in response to it.
    typedef enum logic [1:0] {ARB = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nx;
    logic              rr;
    logic [ADDR_W-1:0] cnt;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              suppress;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;

    always_ff @(posedge CLK) begin
        if (!reset) state <= ARB;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARB:     if (clr_start) state_nx = CLEAR;
            CLEAR:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = ARB;
            default: state_nx = ARB;
        endcase
    end

    // Clear wins over pending requests; ready is also held low while reset is asserted.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        clr_busy = (state != ARB);
        clr_done = (state == DONE);
        if (state == ARB && !clr_start && reset) begin
            if (req0_valid && (!req1_valid || !rr)) grant0 = 1'b1;
            else if (req1_valid)                    grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;
    assign acc_rd     = grant0 ? req0_rd : req1_rd;
    assign acc_data   = grant0 ? req0_data : req1_data;
    assign suppress   = (ZERO_X0 != 0) && (acc_rd == '0);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            rr      <= 1'b0;
            cnt     <= '0;
            wenable <= 1'b0;
            rd      <= '0;
            Dc      <= '0;
        end else begin
            case (state)
                ARB: begin
                    cnt <= '0;
                    if (accept) begin
                        rd      <= acc_rd;
                        Dc      <= acc_data;
                        wenable <= !suppress;
                        // x0-suppressed accepts leave the pointer where it was
                        if (!suppress) rr <= ~rr;
                    end else begin
                        wenable <= 1'b0;
                    end
                end
                CLEAR: begin
                    wenable <= 1'b1;
                    rd      <= cnt;
                    Dc      <= '0;
                    cnt     <= cnt + ADDR_W'(1);
                end
                default: wenable <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a behavioural
// model (clear countdown, done flag, favoured requester, expected-write queue).
module tb_regfile_write_arbiter;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = AW + DW;

    logic          CLK = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_rd, req1_rd;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          clr_start, clr_busy, clr_done;
    logic          wenable;
    logic [AW-1:0] rd;
    logic [DW-1:0] Dc;

    regfile_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .ZERO_X0(1)) dut (
        .CLK(CLK), .reset(reset),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .wenable(wenable), .rd(rd), .Dc(Dc)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // behavioural model
    int          m_clr_left = 0;
    bit          m_done     = 0;
    bit          m_favor1   = 0;
    bit          m_rst_chk  = 0;
    logic [W-1:0] exp_q[$];
    logic        exp_r0, exp_r1;

    // observations for directed sections
    logic        seen_r0, seen_done, seen_we;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic cycle();
        bit busy_e;
        logic [W-1:0] e;
        #1;
        busy_e = (m_clr_left > 0) || m_done;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (reset && !busy_e && !clr_start) begin
            if (req0_valid && (!req1_valid || !m_favor1)) exp_r0 = 1'b1;
            else if (req1_valid)                         exp_r1 = 1'b1;
        end
        check("req0_ready", 64'(req0_ready), 64'(exp_r0));
        check("req1_ready", 64'(req1_ready), 64'(exp_r1));
        check("clr_busy", 64'(clr_busy), 64'(busy_e));
        check("clr_done", 64'(clr_done), 64'(m_done));
        seen_r0   = req0_ready;
        seen_done = clr_done;

        if (!reset) begin
            m_clr_left = 0;
            m_done     = 1'b0;
            m_favor1   = 1'b0;
            m_rst_chk  = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_clr_left > 0) begin
            exp_q.push_back({AW'(NR - m_clr_left), DW'(0)});
            m_clr_left--;
            if (m_clr_left == 0) m_done = 1'b1;
        end else if (clr_start) begin
            m_clr_left = NR;
        end else if (exp_r0 || exp_r1) begin
            if ((exp_r0 ? req0_rd : req1_rd) != 0) begin
                exp_q.push_back(exp_r0 ? {req0_rd, req0_data} : {req1_rd, req1_data});
                m_favor1 = !m_favor1;
            end
        end

        @(posedge CLK);
        #1;
        seen_we = wenable;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wenable", 64'(wenable), 64'(1));
            check("rd", 64'(rd), 64'(e[W-1:DW]));
            check("Dc", 64'(Dc), 64'(e[DW-1:0]));
        end else begin
            check("wenable", 64'(wenable), 64'(0));
        end
        if (m_rst_chk) begin
            check("rst_rd", 64'(rd), 64'(0));
            check("rst_Dc", 64'(Dc), 64'(0));
            m_rst_chk = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] pattern;
        int done_cnt, we_cnt;

        reset = 1'b0; clr_start = 1'b0;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        @(posedge CLK); #1;

        // reset held with a pending request, then served on release
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h0000_0055;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        check("first_grant_req0", 64'(seen_r0), 64'(1));
        req0_valid = 1'b0;

        // single write from req1
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'hDEADBEEF;
        cycle();
        req1_valid = 1'b0;
        cycle();

        // contention: grants alternate starting with req0
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h3333_0000;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h4444_0000;
        pattern = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pattern = {pattern[2:0], seen_r0};
        end
        check("alternation", 64'(pattern), 64'(4'b1010));
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // x0 suppression keeps the pointer on req0
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'h1;
        cycle();
        req0_rd = 5'd9; req0_data = 32'h9;
        req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'hA;
        cycle();
        check("x0_keeps_pointer", 64'(seen_r0), 64'(1));
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // clear with a pending req1 in the same cycle
        req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'hC0FFEE;
        clr_start = 1'b1;
        done_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            cycle();
            clr_start = 1'b0;
            done_cnt += int'(seen_done);
            we_cnt   += int'(seen_we);
        end
        check("clear_writes", 64'(we_cnt), 64'(NR));
        check("clear_done_pulses", 64'(done_cnt), 64'(1));
        cycle();
        req1_valid = 1'b0;

        // abort at counter 10; a second clr_start during the sweep is ignored
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clr_start = (i == 5);
            cycle();
        end
        clr_start = 1'b0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            done_cnt += int'(seen_done);
        end
        check("abort_no_done", 64'(done_cnt), 64'(0));

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_rd    = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, NR - 1));
                req0_data  = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_rd    = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, NR - 1));
                req1_data  = $urandom;
            end
            clr_start = ($urandom_range(0, 149) == 0);
            reset     = ($urandom_range(0, 499) != 0);
            cycle();
            if (exp_r0) req0_valid = 1'b0;
            if (exp_r1) req1_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (rd, Dc, wenable) of the 32x32 register file.
- Shares that port between two writeback requesters (req0 = ALU writeback, req1 = load writeback) using round-robin arbitration and a valid/ready handshake.
- Also sequences a "clear all" operation that writes zero to every register, one register per cycle.
- Sits between the execute/load stages and the register file's write inputs.

Parameters:
- NUM_REGS, 32, number of registers swept by a clear; the highest address cleared is NUM_REGS-1.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- ZERO_X0, 1, when 1 a write to address 0 is accepted but never drives wenable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_rd  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_rd  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- clr_start  in  1  request to zero all registers.
- clr_busy  out  1  clear in progress; no requests are accepted.
- clr_done  out  1  one-cycle pulse when the clear finishes.
- wenable  out  1  register file write enable (registered).
- rd  out  ADDR_W  register file write address (registered).
- Dc  out  DATA_W  register file write data (registered).

Behaviour:
- Single clock. Reset is synchronous and active-low: sampled only on the CLK rising edge, takes effect when reset=0.
- Reset: state=ARB, rr pointer=req0, clear counter=0, wenable=0, rd=0, Dc=0. clr_busy, clr_done, req0_ready and req1_ready are all 0 in the cycle after reset.
- Reset mid-clear aborts the clear. No clr_done pulse is produced.
- States: ARB, CLEAR, DONE.
  - clr_busy=1 in CLEAR and DONE.
  - clr_done=1 only in DONE.
- ARB, clr_start=1:
  - Next state is CLEAR, counter=0.
  - Both ready outputs are 0 this cycle; clear has priority over pending requests.
  - The registered outputs load wenable=0.
- ARB, clr_start=0:
  - Grant is combinational from the valids and the rr pointer.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by the pointer gets ready=1, the other gets 0.
  - Neither valid: both ready=0.
- Handshake completes when valid and ready are both 1. Requesters hold valid, rd and data stable until ready is seen.
- Accepted write: on that edge the outputs load wenable=1, rd=req_rd, Dc=req_data. Latency from handshake to the register file write is 1 cycle: the file captures the data on the following edge.
- ZERO_X0=1 and accepted rd=0: the handshake still completes (ready=1), but wenable loads 0.
- rr pointer:
  - Toggles to the other requester after every accepted write.
  - Unchanged on idle cycles, on x0-suppressed accepts, and during clear.
- No accept in a cycle: wenable loads 0. rd and Dc may hold their previous values.
- CLEAR:
  - Each edge loads wenable=1, rd=counter, Dc=0, then increments counter.
  - When the counter is NUM_REGS-1 on that edge, next state is DONE.
  - Address 0 is written too; ZERO_X0 does not suppress clear writes.
  - Result: NUM_REGS consecutive cycles with wenable=1, addresses 0..NUM_REGS-1 in order.
- DONE: lasts one cycle. Loads wenable=0, then returns to ARB.
- clr_start while in CLEAR or DONE is ignored; it is not queued.
- Both ready outputs are 0 throughout CLEAR and DONE. A request pending during the clear is served in the first ARB cycle afterwards, subject to clr_start in that cycle.
- Max throughput is one write per cycle. Back-to-back requests from both requesters alternate 0,1,0,1.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req0_valid=1 -> wenable=0, rd=0, Dc=0, both ready=0, clr_busy=0. First ARB cycle after release -> req0_ready=1.
- Single write: req1_valid=1, rd=7, data=32'hDEADBEEF -> req1_ready=1 that cycle. Next cycle wenable=1, rd=7, Dc=32'hDEADBEEF. Following cycle wenable=0.
- Contention: both valid for 4 cycles, req0 rd=3, req1 rd=4, pointer=req0 -> grants alternate 0,1,0,1. wenable high 4 consecutive cycles with rd=3,4,3,4.
- x0 suppression: req0_valid with rd=0, data=32'h1 -> req0_ready=1, wenable stays 0. The pointer still favours req0 on the next contention.
- Clear: pulse clr_start with req1_valid=1 in the same cycle -> req1_ready=0. wenable=1 for 32 cycles with rd=0..31 and Dc=0. clr_done=1 for exactly one cycle. req1_ready=1 in the next cycle.
- Abort: reset=0 when the clear counter=10 -> wenable=0 next cycle, state ARB, no clr_done pulse. A clr_start during CLEAR does not extend the sweep.
